ofifo_bank: RTL and testbench
=============================

// Module: ofifo_bank
// PURPOSE
//  Output FIFO bank for the PE array: one independent FIFO lane per array column, filled as
//  column results arrive at different times (skewed per-column wr), drained as full rows.
//  Successor to the fixed depth-16 output FIFO: parametrised depth, almost-full watermark,
//  min-occupancy report, defined overflow/underflow handling. Sits between mac_array and SRAM writeback.
// PARAMETERS
//  COL    8    number of column lanes
//  BW     16   data width per lane (bits)
//  DEPTH  16   entries per lane; power of 2, >= 4
//  AF_TH  14   almost-full threshold (entries); 1 <= AF_TH <= DEPTH
// PORTS
//  clk            in   1               clock, all logic on posedge
//  reset          in   1               synchronous, active-high
//  wr             in   COL             per-lane push strobe
//  in             in   BW*COL          lane i data at in[BW*(i+1)-1:BW*i]
//  rd             in   1               row pop request (all lanes at once)
//  out            out  BW*COL          registered row output, lane i at out[BW*(i+1)-1:BW*i]
//  o_full         out  1               any lane full
//  o_ready        out  1               no lane full
//  o_almost_full  out  1               any lane count >= AF_TH
//  o_valid        out  1               every lane non-empty (a full row is poppable)
//  o_min_level    out  $clog2(DEPTH)+1 minimum lane occupancy
//  o_rd_vld       out  1               out carries a freshly popped row this cycle
// BEHAVIOUR
//  - Reset: pointers/counts 0; out=0, o_rd_vld=0, o_valid=0, o_full=0, o_ready=1, o_almost_full=0,
//    o_min_level=0. Memory contents not reset. Reset mid-operation discards all data in one cycle.
//  - Per lane: wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits (extra wrap bit); empty = ptrs equal;
//    full = low bits equal, wrap bits differ. count = wr_ptr - rd_ptr (modular).
//  - Push: lane i accepts iff wr[i] && !full[i] (pre-edge state). Write to a full lane is dropped.
//  - Pop: accepted iff rd && o_valid (pre-edge state); all lanes advance rd_ptr together.
//    rd with !o_valid is ignored; o_rd_vld stays 0, out holds.
//  - Latency: pop accepted at edge N -> out and o_rd_vld=1 valid after edge N (1 cycle after rd
//    sampled); out holds last popped row until next accepted pop; o_rd_vld is a 1-cycle pulse.
//  - Write-to-read: data pushed at edge N is poppable from cycle after edge N if all lanes non-empty.
//  - Simultaneous push+pop on one lane: both occur, count unchanged. Full lane + pop: push still
//    dropped (flags are pre-edge). Empty lane + push: pop not accepted (o_valid was 0).
//  - Pointer wrap at DEPTH is seamless; back-to-back pops every cycle sustain 1 row/cycle.
//  - Flags/o_min_level are combinational from registered pointers (no comb path from wr/rd).
// CONFIGURATION
//  OFIFO_BANK_ERR_EN defined: adds ports err_clr (in,1), o_ovf (out,COL), o_udf (out,1).
//    o_ovf[i] sets sticky on dropped push to lane i; o_udf sets sticky on rd with !o_valid;
//    both cleared by reset or err_clr (err_clr wins over a same-cycle set). Reset value 0.
//  Not defined: those ports and error logic absent; drop/ignore behaviour identical.
// STRUCTURE
//  - ofifo_pkg: function clog2-based PTR_W/LVL_W helpers, lane count type; shared with mac_array tb.
//  - Sub-module ofifo_lane (one per column, generate loop): storage, pointers, empty/full/count,
//    1-cycle registered read port. Bank top: pop qualification, flag reduction, min-level tree,
//    o_rd_vld, optional error stickies.
// TESTING
//  1. Reset then idle: o_valid=0, o_ready=1, o_min_level=0; rd=1 -> o_rd_vld stays 0, out=0.
//  2. Skewed fill: lane i written with value 16*i+k at cycle k+i (k=0..3, COL=8) -> o_valid rises
//     only after lane 7's first write; 4 pops return rows k=0..3 in order, o_rd_vld each cycle after.
//  3. Fill lane 0 with 16 writes, 17th write (0xBEEF) -> o_full=1, o_ready=0, o_almost_full at 14th
//     write; 0xBEEF never read back; with ERR_EN o_ovf[0]=1 until err_clr.
//  4. Steady state all lanes count 2, push+pop every cycle for 40 cycles (wraps twice) -> count stays 2,
//     data in order, no flag glitches.
//  5. Mid-stream reset with counts 5: next cycle o_valid=0, o_min_level=0; new writes read back cleanly.
//  6. Lanes counts {3,7,1,...}: o_min_level=1; one pop -> 0, o_valid=0.

Source files
------------

// File: rtl/ofifo_bank_pkg.sv
// ofifo_bank_pkg
//   Shared helpers for the output FIFO bank and its neighbours (mac_array bench).
//   Provides the default geometry, pointer/level width helpers and a lane
//   occupancy type sized for the default depth.
//   Optional error reporting in the bank is enabled with OFIFO_BANK_ERR_EN.
package ofifo_bank_pkg;

    localparam int DEF_COL   = 8;
    localparam int DEF_BW    = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AF_TH = 14;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A level must represent 0..DEPTH inclusive.
    function automatic int lvlWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [lvlWidth(DEF_DEPTH)-1:0] lane_cnt_t;

endpackage

// File: rtl/ofifo_bank_if.sv
// ofifo_bank_if
//   Bus between the producer/consumer side and the output FIFO bank.
//   master : drives wr (per-lane push), in (row data), rd (row pop)
//   slave  : drives out (registered row), o_full, o_ready, o_almost_full,
//            o_valid, o_min_level, o_rd_vld
//   With OFIFO_BANK_ERR_EN: err_clr (master), o_ovf/o_udf (slave).
interface ofifo_bank_if
    import ofifo_bank_pkg::*;
#(
    parameter int COL   = 8,
    parameter int BW    = 16,
    parameter int DEPTH = 16
);
    localparam int LVL_W = lvlWidth(DEPTH);

    logic [COL-1:0]    wr;
    logic [BW*COL-1:0] in;
    logic              rd;
    logic [BW*COL-1:0] out;
    logic              o_full;
    logic              o_ready;
    logic              o_almost_full;
    logic              o_valid;
    logic [LVL_W-1:0]  o_min_level;
    logic              o_rd_vld;
`ifdef OFIFO_BANK_ERR_EN
    logic              err_clr;
    logic [COL-1:0]    o_ovf;
    logic              o_udf;

    modport master (
        output wr, in, rd, err_clr,
        input  out, o_full, o_ready, o_almost_full, o_valid, o_min_level, o_rd_vld,
               o_ovf, o_udf
    );
    modport slave (
        input  wr, in, rd, err_clr,
        output out, o_full, o_ready, o_almost_full, o_valid, o_min_level, o_rd_vld,
               o_ovf, o_udf
    );
`else
    modport master (
        output wr, in, rd,
        input  out, o_full, o_ready, o_almost_full, o_valid, o_min_level, o_rd_vld
    );
    modport slave (
        input  wr, in, rd,
        output out, o_full, o_ready, o_almost_full, o_valid, o_min_level, o_rd_vld
    );
`endif
endinterface

// File: rtl/ofifo_bank_lane.sv
// ofifo_bank_lane
//   One column lane of the output FIFO bank: storage, wrap-bit pointers,
//   empty/full/count status and a registered read port.
//   clk, reset : clock, synchronous active-high reset
//   wr_i       : push strobe (dropped when the lane is full)
//   data_i     : push data
//   pop_i      : pop strobe, already qualified by the bank (lane never empty)
//   full_o, empty_o, count_o : status from registered pointers
//   data_o     : last popped word, updated the cycle after a pop
module ofifo_bank_lane
    import ofifo_bank_pkg::*;
#(
    parameter int BW    = 16,
    parameter int DEPTH = 16,
    localparam int PTR_W = ptrWidth(DEPTH),
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [BW-1:0]    data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o,
    output logic [BW-1:0]    data_o
);
    logic [BW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [BW-1:0]    dataOut_q, dataOut_d;
    logic             pushOk;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign count_o = wrPtr_q - rdPtr_q;
    assign pushOk  = wr_i && !full_o;
    assign data_o  = dataOut_q;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        dataOut_d = dataOut_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rdPtr_d   = rdPtr_q + PTR_W'(1);
            dataOut_d = mem_q[rdPtr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            dataOut_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            dataOut_q <= dataOut_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ofifo_bank.sv
// ofifo_bank
//   Output FIFO bank between mac_array and SRAM writeback: one FIFO lane per
//   array column, filled per lane with skew, drained as whole rows.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ofifo_bank_if.slave (wr/in/rd in; out, o_full, o_ready,
//                o_almost_full, o_valid, o_min_level, o_rd_vld out)
//   Macro OFIFO_BANK_ERR_EN adds err_clr, o_ovf (per lane) and o_udf stickies.
module ofifo_bank
    import ofifo_bank_pkg::*;
#(
    parameter int COL   = DEF_COL,
    parameter int BW    = DEF_BW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AF_TH = DEF_AF_TH,
    localparam int LVL_W = lvlWidth(DEPTH)
)(
    input logic         clk,
    input logic         reset,
    ofifo_bank_if.slave bus
);
    logic [COL-1:0]    laneFull;
    logic [COL-1:0]    laneEmpty;
    logic [LVL_W-1:0]  laneCount [COL];
    logic [BW-1:0]     laneData  [COL];
    logic              allNonEmpty;
    logic              anyAf;
    logic [LVL_W-1:0]  minLvl;
    logic [BW*COL-1:0] outRow;
    logic              popAccept;
    logic              rdVld_q, rdVld_d;

    // A row pop is only honoured when every lane has an entry, so no lane
    // ever advances its read pointer past its write pointer.
    assign popAccept = bus.rd && allNonEmpty;

    for (genvar g = 0; g < COL; g++) begin : gLane
        ofifo_bank_lane #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) uLane (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (bus.wr[g]),
            .data_i  (bus.in[BW*g +: BW]),
            .pop_i   (popAccept),
            .full_o  (laneFull[g]),
            .empty_o (laneEmpty[g]),
            .count_o (laneCount[g]),
            .data_o  (laneData[g])
        );
    end

    // Status reduction across lanes, all from registered pointers.
    always_comb begin
        allNonEmpty = ~|laneEmpty;
        anyAf       = 1'b0;
        minLvl      = laneCount[0];
        outRow      = '0;
        for (int i = 0; i < COL; i++) begin
            if (laneCount[i] >= LVL_W'(AF_TH)) begin
                anyAf = 1'b1;
            end
            if (laneCount[i] < minLvl) begin
                minLvl = laneCount[i];
            end
            outRow[BW*i +: BW] = laneData[i];
        end
    end

    assign rdVld_d = popAccept;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdVld_q <= 1'b0;
        end else begin
            rdVld_q <= rdVld_d;
        end
    end

    assign bus.out           = outRow;
    assign bus.o_full        = |laneFull;
    assign bus.o_ready       = ~|laneFull;
    assign bus.o_almost_full = anyAf;
    assign bus.o_valid       = allNonEmpty;
    assign bus.o_min_level   = minLvl;
    assign bus.o_rd_vld      = rdVld_q;

`ifdef OFIFO_BANK_ERR_EN
    logic [COL-1:0] ovf_q, ovf_d;
    logic           udf_q, udf_d;

    // Sticky error flags; a clear in the same cycle as a new event wins.
    always_comb begin
        ovf_d = ovf_q | (bus.wr & laneFull);
        udf_d = udf_q | (bus.rd & ~allNonEmpty);
        if (bus.err_clr) begin
            ovf_d = '0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.o_ovf = ovf_q;
    assign bus.o_udf = udf_q;
`endif

endmodule

// File: tb/tb_ofifo_bank.sv
// tb_ofifo_bank
//   Self-checking bench for ofifo_bank. A queue-per-lane reference model
//   predicts every output; directed scenarios are followed by random traffic.
//   Works with and without OFIFO_BANK_ERR_EN.
module tb_ofifo_bank;
    import ofifo_bank_pkg::*;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;
    localparam int AF_TH = 14;
    localparam int LVL_W = lvlWidth(DEPTH);
    localparam int W     = BW * COL;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    logic [BW-1:0]    mq [COL][$];
    logic [W-1:0]     expOut;
    logic             expRdVld;
    logic [COL-1:0]   expOvf;
    logic             expUdf;

    ofifo_bank_if #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) bus ();

    ofifo_bank #(
        .COL   (COL),
        .BW    (BW),
        .DEPTH (DEPTH),
        .AF_TH (AF_TH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected if it differs.
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all DUT outputs against values derived from the model queues.
    task automatic checkOutput(input string step);
        logic           eFull, eAf, eValid;
        int             eMin;
        eFull  = 1'b0;
        eAf    = 1'b0;
        eValid = 1'b1;
        eMin   = DEPTH;
        for (int i = 0; i < COL; i++) begin
            if (mq[i].size() == DEPTH) eFull = 1'b1;
            if (mq[i].size() >= AF_TH) eAf = 1'b1;
            if (mq[i].size() == 0) eValid = 1'b0;
            if (mq[i].size() < eMin) eMin = mq[i].size();
        end
        chk({step, ":full"},   W'(bus.o_full),        W'(eFull));
        chk({step, ":ready"},  W'(bus.o_ready),       W'(!eFull));
        chk({step, ":af"},     W'(bus.o_almost_full), W'(eAf));
        chk({step, ":valid"},  W'(bus.o_valid),       W'(eValid));
        chk({step, ":minlvl"}, W'(bus.o_min_level),   W'(eMin));
        chk({step, ":rdvld"},  W'(bus.o_rd_vld),      W'(expRdVld));
        chk({step, ":out"},    bus.out,               expOut);
`ifdef OFIFO_BANK_ERR_EN
        chk({step, ":ovf"},    W'(bus.o_ovf),         W'(expOvf));
        chk({step, ":udf"},    W'(bus.o_udf),         W'(expUdf));
`endif
    endtask

    // Reset for one edge, clear the model, then check reset values.
    task automatic resetDut(input string step);
        reset  = 1'b1;
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
`ifdef OFIFO_BANK_ERR_EN
        bus.err_clr = 1'b0;
`endif
        @(posedge clk);
        for (int i = 0; i < COL; i++) mq[i].delete();
        expOut   = '0;
        expRdVld = 1'b0;
        expOvf   = '0;
        expUdf   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput(step);
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then check.
    task automatic applyStimulus(input string step, input logic [COL-1:0] w,
                                 input logic [W-1:0] d, input logic r, input logic clr);
        logic           canPop;
        logic [COL-1:0] fullPre;
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
`ifdef OFIFO_BANK_ERR_EN
        bus.err_clr = clr;
`endif
        canPop = 1'b1;
        for (int i = 0; i < COL; i++) begin
            fullPre[i] = (mq[i].size() == DEPTH);
            if (mq[i].size() == 0) canPop = 1'b0;
        end
        @(posedge clk);
        expRdVld = r && canPop;
        if (r && canPop) begin
            for (int i = 0; i < COL; i++) expOut[BW*i +: BW] = mq[i].pop_front();
        end
        for (int i = 0; i < COL; i++) begin
            if (w[i] && !fullPre[i]) mq[i].push_back(d[BW*i +: BW]);
        end
        if (clr) begin
            expOvf = '0;
            expUdf = 1'b0;
        end else begin
            expOvf = expOvf | (w & fullPre);
            expUdf = expUdf | (r && !canPop);
        end
        @(negedge clk);
        bus.wr = '0;
        bus.rd = 1'b0;
        checkOutput(step);
    endtask

    function automatic logic [W-1:0] randRow();
        logic [W-1:0] v;
        for (int i = 0; i < COL; i++) v[BW*i +: BW] = BW'($urandom);
        return v;
    endfunction

    initial begin
        logic [W-1:0]   d;
        logic [COL-1:0] w;
        int             cnt [COL];
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.wr      = '0;
        bus.rd      = 1'b0;
        bus.in      = '0;
`ifdef OFIFO_BANK_ERR_EN
        bus.err_clr = 1'b0;
`endif
        @(negedge clk);

        // 1. Reset then idle, including a pop request on an empty bank.
        resetDut("t1_reset");
        applyStimulus("t1_idle", '0, '0, 1'b0, 1'b0);
        applyStimulus("t1_rd_empty", '0, '0, 1'b1, 1'b0);
        applyStimulus("t1_after", '0, '0, 1'b0, 1'b0);

        // 2. Skewed fill: lane i receives 16*i+k at cycle k+i, then four pops.
        resetDut("t2_reset");
        for (int t = 0; t <= 10; t++) begin
            w = '0;
            d = '0;
            for (int i = 0; i < COL; i++) begin
                if (t - i >= 0 && t - i <= 3) begin
                    w[i] = 1'b1;
                    d[BW*i +: BW] = BW'(16 * i + (t - i));
                end
            end
            applyStimulus("t2_fill", w, d, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) applyStimulus("t2_pop", '0, '0, 1'b1, 1'b0);
        applyStimulus("t2_idle", '0, '0, 1'b0, 1'b0);

        // 3. Overfill lane 0; the dropped 0xBEEF must never appear on out.
        resetDut("t3_reset");
        for (int k = 0; k < 17; k++) begin
            d = '0;
            d[BW-1:0] = (k < 16) ? BW'(k) : 16'hBEEF;
            applyStimulus("t3_fill0", 8'h01, d, 1'b0, 1'b0);
        end
        applyStimulus("t3_hold", '0, '0, 1'b0, 1'b0);
        applyStimulus("t3_clr", '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) applyStimulus("t3_fillrest", 8'hFE, randRow(), 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) applyStimulus("t3_drain", '0, '0, 1'b1, 1'b0);
        applyStimulus("t3_idle", '0, '0, 1'b0, 1'b0);

        // 4. Steady state at depth 2 with push+pop every cycle across wraps.
        resetDut("t4_reset");
        applyStimulus("t4_prime", '1, randRow(), 1'b0, 1'b0);
        applyStimulus("t4_prime", '1, randRow(), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) applyStimulus("t4_stream", '1, randRow(), 1'b1, 1'b0);

        // 5. Mid-stream reset discards data; fresh traffic afterwards.
        resetDut("t5_reset");
        for (int k = 0; k < 5; k++) applyStimulus("t5_fill", '1, randRow(), 1'b0, 1'b0);
        resetDut("t5_midreset");
        applyStimulus("t5_refill", '1, randRow(), 1'b0, 1'b0);
        applyStimulus("t5_refill", '1, randRow(), 1'b0, 1'b0);
        applyStimulus("t5_pop", '0, '0, 1'b1, 1'b0);
        applyStimulus("t5_pop", '0, '0, 1'b1, 1'b0);

        // 6. Uneven lane levels {3,7,1,2,...}; one pop empties lane 2.
        resetDut("t6_reset");
        cnt = '{3, 7, 1, 2, 2, 2, 2, 2};
        for (int k = 0; k < 7; k++) begin
            w = '0;
            for (int i = 0; i < COL; i++) w[i] = (k < cnt[i]);
            applyStimulus("t6_fill", w, randRow(), 1'b0, 1'b0);
        end
        applyStimulus("t6_pop", '0, '0, 1'b1, 1'b0);
        applyStimulus("t6_pop_empty", '0, '0, 1'b1, 1'b0);

        // 7. Random traffic with alternating fill-heavy and drain-heavy phases.
        resetDut("t7_reset");
        for (int k = 0; k < 400; k++) begin
            logic r;
            w = COL'($urandom);
            if ((k / 50) % 2 == 0) begin
                w = w | COL'($urandom);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = w & COL'($urandom);
                r = ($urandom_range(0, 3) != 0);
            end
            applyStimulus("t7_rand", w, randRow(), r, ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
